// File: rtl/fixed_mac_pkg.sv
// Shared types, default widths and helpers for the fixed_mac round-robin scheduler.
package fixed_mac_pkg;

  localparam int unsigned DEF_NREQ = 2;
  localparam int unsigned DEF_WI1  = 6;
  localparam int unsigned DEF_WF1  = 10;
  localparam int unsigned DEF_WI2  = 4;
  localparam int unsigned DEF_WF2  = 8;
  localparam int unsigned DEF_WIO  = 7;
  localparam int unsigned DEF_WFO  = 13;

  localparam int unsigned A_W = DEF_WI1 + DEF_WF1;
  localparam int unsigned B_W = DEF_WI2 + DEF_WF2;
  localparam int unsigned O_W = DEF_WIO + DEF_WFO;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    RESULT = 2'd2
  } state_e;

  // Requester-id width, never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    if (n < 2) return 1;
    return unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, in index order.
module rr_arbiter
  import fixed_mac_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [id_w(NREQ)-1:0]   ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [id_w(NREQ)-1:0]   id_o,
  output logic                    any_o
);

  localparam int unsigned IDW = id_w(NREQ);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/fixed_mac_rr_scheduler.sv
// Shares one fixed_mac between NREQ requesters; a grant spans both operand streams
// through their last beats plus the single result beat.
module fixed_mac_rr_scheduler
  import fixed_mac_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned WI1  = DEF_WI1,
  parameter int unsigned WF1  = DEF_WF1,
  parameter int unsigned WI2  = DEF_WI2,
  parameter int unsigned WF2  = DEF_WF2,
  parameter int unsigned WIO  = DEF_WIO,
  parameter int unsigned WFO  = DEF_WFO
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ*(WI1+WF1)-1:0]   req_A_data,
  input  logic [NREQ-1:0]             req_A_valid,
  input  logic [NREQ-1:0]             req_A_last,
  output logic [NREQ-1:0]             req_A_ready,
  input  logic [NREQ*(WI2+WF2)-1:0]   req_B_data,
  input  logic [NREQ-1:0]             req_B_valid,
  input  logic [NREQ-1:0]             req_B_last,
  output logic [NREQ-1:0]             req_B_ready,
  input  logic [NREQ-1:0]             req_of_sat,
  input  logic [NREQ-1:0]             req_uf_sat,
  output logic [WIO+WFO-1:0]          req_out_data,
  output logic [NREQ-1:0]             req_out_valid,
  input  logic [NREQ-1:0]             req_out_ready,
  output logic                        req_overflow,
  output logic                        req_underflow,
  output logic [WI1+WF1-1:0]          mac_A_data,
  output logic                        mac_A_valid,
  output logic                        mac_A_last,
  input  logic                        mac_A_ready,
  output logic [WI2+WF2-1:0]          mac_B_data,
  output logic                        mac_B_valid,
  output logic                        mac_B_last,
  input  logic                        mac_B_ready,
  input  logic [WIO+WFO-1:0]          mac_out_data,
  input  logic                        mac_out_valid,
  output logic                        mac_out_ready,
  input  logic                        mac_overflow,
  input  logic                        mac_underflow,
  output logic                        mac_OF_saturation,
  output logic                        mac_UF_saturation,
  output logic                        busy,
  output logic [id_w(NREQ)-1:0]       grant_id
);

  localparam int unsigned AW  = WI1 + WF1;
  localparam int unsigned BW  = WI2 + WF2;
  localparam int unsigned IDW = id_w(NREQ);

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           a_done_q, a_done_d;
  logic           b_done_q, b_done_d;
  logic           of_sat_q, of_sat_d;
  logic           uf_sat_q, uf_sat_d;

  logic [NREQ-1:0] req_vec;
  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;

  logic [AW-1:0] a_arr [NREQ];
  logic [BW-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_A_data[g*AW +: AW];
    assign b_arr[g] = req_B_data[g*BW +: BW];
  end

  assign req_vec = req_A_valid | req_B_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req_vec),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .id_o  (arb_id),
    .any_o (arb_any)
  );

  // Next-state, owner muxing and handshake bookkeeping.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    a_done_d      = a_done_q;
    b_done_d      = b_done_q;
    of_sat_d      = of_sat_q;
    uf_sat_d      = uf_sat_q;
    req_A_ready   = '0;
    req_B_ready   = '0;
    req_out_valid = '0;
    mac_out_ready = 1'b0;
    mac_A_valid   = 1'b0;
    mac_B_valid   = 1'b0;
    mac_A_data    = a_arr[grant_q];
    mac_B_data    = b_arr[grant_q];
    mac_A_last    = req_A_last[grant_q];
    mac_B_last    = req_B_last[grant_q];
    req_out_data  = mac_out_data;
    req_overflow  = mac_overflow;
    req_underflow = mac_underflow;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d  = arb_id;
          of_sat_d = |(req_of_sat & arb_gnt);
          uf_sat_d = |(req_uf_sat & arb_gnt);
          state_d  = STREAM;
        end
      end
      STREAM: begin
        mac_A_valid          = req_A_valid[grant_q] & ~a_done_q;
        mac_B_valid          = req_B_valid[grant_q] & ~b_done_q;
        req_A_ready[grant_q] = mac_A_ready & ~a_done_q;
        req_B_ready[grant_q] = mac_B_ready & ~b_done_q;
        if (mac_A_valid && mac_A_ready && mac_A_last) a_done_d = 1'b1;
        if (mac_B_valid && mac_B_ready && mac_B_last) b_done_d = 1'b1;
        if (a_done_d && b_done_d) state_d = RESULT;
      end
      RESULT: begin
        req_out_valid[grant_q] = mac_out_valid;
        mac_out_ready          = req_out_ready[grant_q];
        if (mac_out_valid && mac_out_ready) begin
          ptr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          a_done_d = 1'b0;
          b_done_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      of_sat_q <= 1'b0;
      uf_sat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      of_sat_q <= of_sat_d;
      uf_sat_q <= uf_sat_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign grant_id          = grant_q;
  assign mac_OF_saturation = of_sat_q;
  assign mac_UF_saturation = uf_sat_q;

endmodule

// File: tb/tb_fixed_mac_rr_scheduler.sv
// Randomized directed bench: queued requester jobs, a stub fixed_mac, and a job-level
// round-robin model predicting owner, beat flow, result routing and saturation latching.
module tb_fixed_mac_rr_scheduler;
  import fixed_mac_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = id_w(NREQ);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wire  [NREQ*A_W-1:0] req_A_data;
  wire  [NREQ-1:0]     req_A_valid, req_A_last;
  logic [NREQ-1:0]     req_A_ready;
  wire  [NREQ*B_W-1:0] req_B_data;
  wire  [NREQ-1:0]     req_B_valid, req_B_last;
  logic [NREQ-1:0]     req_B_ready;
  wire  [NREQ-1:0]     req_of_sat, req_uf_sat, req_out_ready;
  logic [O_W-1:0]      req_out_data;
  logic [NREQ-1:0]     req_out_valid;
  logic                req_overflow, req_underflow;
  logic [A_W-1:0]      mac_A_data;
  logic                mac_A_valid, mac_A_last, mac_A_ready;
  logic [B_W-1:0]      mac_B_data;
  logic                mac_B_valid, mac_B_last, mac_B_ready;
  logic [O_W-1:0]      mac_out_data;
  logic                mac_out_valid, mac_out_ready, mac_overflow, mac_underflow;
  logic                mac_OF_saturation, mac_UF_saturation, busy;
  logic [IDW-1:0]      grant_id;

  // Requester-side drive state, one slot per requester.
  bit             a_vld [NREQ], a_lst [NREQ], b_vld [NREQ], b_lst [NREQ];
  bit             of_s [NREQ], uf_s [NREQ], or_rdy [NREQ];
  logic [A_W-1:0] a_dat [NREQ];
  logic [B_W-1:0] b_dat [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_A_data[g*A_W +: A_W] = a_dat[g];
    assign req_B_data[g*B_W +: B_W] = b_dat[g];
    assign req_A_valid[g]   = a_vld[g];
    assign req_A_last[g]    = a_lst[g];
    assign req_B_valid[g]   = b_vld[g];
    assign req_B_last[g]    = b_lst[g];
    assign req_of_sat[g]    = of_s[g];
    assign req_uf_sat[g]    = uf_s[g];
    assign req_out_ready[g] = or_rdy[g];
  end

  fixed_mac_rr_scheduler #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_A_data(req_A_data), .req_A_valid(req_A_valid), .req_A_last(req_A_last), .req_A_ready(req_A_ready),
    .req_B_data(req_B_data), .req_B_valid(req_B_valid), .req_B_last(req_B_last), .req_B_ready(req_B_ready),
    .req_of_sat(req_of_sat), .req_uf_sat(req_uf_sat),
    .req_out_data(req_out_data), .req_out_valid(req_out_valid), .req_out_ready(req_out_ready),
    .req_overflow(req_overflow), .req_underflow(req_underflow),
    .mac_A_data(mac_A_data), .mac_A_valid(mac_A_valid), .mac_A_last(mac_A_last), .mac_A_ready(mac_A_ready),
    .mac_B_data(mac_B_data), .mac_B_valid(mac_B_valid), .mac_B_last(mac_B_last), .mac_B_ready(mac_B_ready),
    .mac_out_data(mac_out_data), .mac_out_valid(mac_out_valid), .mac_out_ready(mac_out_ready),
    .mac_overflow(mac_overflow), .mac_underflow(mac_underflow),
    .mac_OF_saturation(mac_OF_saturation), .mac_UF_saturation(mac_UF_saturation),
    .busy(busy), .grant_id(grant_id)
  );

  // Pending job per requester: beat memories with head pointers.
  logic [A_W-1:0] amem [NREQ][64];
  logic [B_W-1:0] bmem [NREQ][64];
  int alen [NREQ], ahd [NREQ], blen [NREQ], bhd [NREQ];
  int ptr_m;
  int n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input int r);
    return (ahd[r] < alen[r]) || (bhd[r] < blen[r]);
  endfunction

  function automatic int pick();
    for (int k = 0; k < int'(NREQ); k++) begin
      int r;
      r = (ptr_m + k) % int'(NREQ);
      if (pending(r)) return r;
    end
    return -1;
  endfunction

  task automatic push_job(input int r, input int na, input int nb,
                          input logic [A_W-1:0] fa, input logic [B_W-1:0] fb);
    for (int i = 0; i < na; i++) amem[r][i] = (i == 0) ? fa : A_W'($urandom);
    for (int i = 0; i < nb; i++) bmem[r][i] = (i == 0) ? fb : B_W'($urandom);
    alen[r] = na; ahd[r] = 0;
    blen[r] = nb; bhd[r] = 0;
  endtask

  task automatic drive(input int ow, input bit gaps);
    for (int r = 0; r < int'(NREQ); r++) begin
      a_vld[r] = (ahd[r] < alen[r]) && !(gaps && r == ow && $urandom_range(0, 3) == 0);
      a_lst[r] = a_vld[r] && (ahd[r] == alen[r] - 1);
      a_dat[r] = a_vld[r] ? amem[r][ahd[r]] : '0;
      b_vld[r] = (bhd[r] < blen[r]) && !(gaps && r == ow && $urandom_range(0, 3) == 0);
      b_lst[r] = b_vld[r] && (bhd[r] == blen[r] - 1);
      b_dat[r] = b_vld[r] ? bmem[r][bhd[r]] : '0;
    end
  endtask

  // One arbitration cycle, then stream/result cycles until the result handshake (or abort).
  task automatic run_job(input int abort_at, input int stall, input bit gaps, input bit drop_sat);
    int             ow, cyc, rcyc;
    logic [IDW-1:0] own;
    logic [NREQ-1:0] om;
    bit             a_dn, b_dn, done, in_res, e_of, e_uf, ofl, ufl;
    int unsigned    sa, sb;
    logic [O_W-1:0] res;
    cyc = 0; rcyc = 0; a_dn = 0; b_dn = 0; done = 0; sa = 0; sb = 0;
    res = '0; ofl = 0; ufl = 0;
    ow = pick();
    n_cmp++;
    assert (ow >= 0) else begin
      n_err++;
      $error("FAIL no_pending: observed %0d expected a requester", ow);
    end
    if (ow < 0) return;
    own = IDW'(ow);
    om  = NREQ'(1) << ow;

    @(posedge clk); #1;
    drive(ow, 1'b0);
    mac_A_ready = 1'b1; mac_B_ready = 1'b1; mac_out_valid = 1'b0;
    for (int r = 0; r < int'(NREQ); r++) or_rdy[r] = 1'b1;
    #1;
    e_of = of_s[ow]; e_uf = uf_s[ow];
    chk("arb_busy", busy, 0);
    chk("arb_ready", {req_A_ready, req_B_ready, mac_out_ready}, 0);
    chk("arb_valid", {mac_A_valid, mac_B_valid, req_out_valid}, 0);

    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      if (abort_at != 0 && cyc == abort_at) return;
      if (drop_sat && cyc == 3)
        for (int r = 0; r < int'(NREQ); r++) begin of_s[r] = 0; uf_s[r] = 0; end
      in_res = a_dn && b_dn;
      drive(ow, gaps && !in_res);
      mac_A_ready   = ($urandom_range(0, 3) != 0);
      mac_B_ready   = ($urandom_range(0, 3) != 0);
      mac_out_valid = in_res;
      mac_out_data  = res;
      mac_overflow  = ofl;
      mac_underflow = ufl;
      for (int r = 0; r < int'(NREQ); r++) or_rdy[r] = ($urandom_range(0, 1) == 1);
      if (in_res) or_rdy[ow] = (rcyc >= stall);
      #1;
      chk("busy", busy, 1);
      chk("grant_id", 32'(grant_id), 32'(ow));
      chk("of_sat", mac_OF_saturation, e_of);
      chk("uf_sat", mac_UF_saturation, e_uf);
      chk("nonowner_ready", 32'((req_A_ready | req_B_ready) & ~om), 0);
      if (!a_dn) begin
        chk("macA_valid", mac_A_valid, a_vld[ow]);
        chk("A_ready", req_A_ready[own], mac_A_ready);
        if (a_vld[ow]) begin
          chk("macA_data", 32'(mac_A_data), 32'(a_dat[ow]));
          chk("macA_last", mac_A_last, a_lst[ow]);
        end
      end else chk("A_closed", {mac_A_valid, req_A_ready[own]}, 0);
      if (!b_dn) begin
        chk("macB_valid", mac_B_valid, b_vld[ow]);
        chk("B_ready", req_B_ready[own], mac_B_ready);
        if (b_vld[ow]) begin
          chk("macB_data", 32'(mac_B_data), 32'(b_dat[ow]));
          chk("macB_last", mac_B_last, b_lst[ow]);
        end
      end else chk("B_closed", {mac_B_valid, req_B_ready[own]}, 0);
      chk("out_valid", 32'(req_out_valid), in_res ? 32'(om) : 0);
      chk("mac_out_ready", mac_out_ready, in_res ? 32'(or_rdy[ow]) : 0);
      if (in_res) begin
        chk("out_data", 32'(req_out_data), 32'(res));
        chk("out_flags", {req_overflow, req_underflow}, {ofl, ufl});
      end
      if (!a_dn && a_vld[ow] && mac_A_ready) begin
        sa += 32'(a_dat[ow]);
        if (a_lst[ow]) a_dn = 1;
        ahd[ow]++;
      end
      if (!b_dn && b_vld[ow] && mac_B_ready) begin
        sb += 32'(b_dat[ow]);
        if (b_lst[ow]) b_dn = 1;
        bhd[ow]++;
      end
      if (in_res) begin
        if (or_rdy[ow]) done = 1;
        rcyc++;
      end else if (a_dn && b_dn) begin
        res = O_W'(sa * 3 + sb);
        ofl = ($urandom_range(0, 1) == 1);
        ufl = ($urandom_range(0, 1) == 1);
      end
      cyc++;
    end
    n_cmp++;
    assert (done) else begin
      n_err++;
      $error("FAIL job_timeout: observed no result handshake after %0d cycles, expected one", cyc);
    end
    ptr_m = (ow + 1) % int'(NREQ);
  endtask

  // The cycle after a result handshake with nothing else pending must be idle.
  task automatic idle_check();
    @(posedge clk); #1; #1;
    chk("idle_busy", busy, 0);
    chk("idle_out", {req_out_valid, mac_out_ready, mac_A_valid, mac_B_valid}, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; ptr_m = 0;
    for (int r = 0; r < int'(NREQ); r++) begin
      alen[r] = 0; ahd[r] = 0; blen[r] = 0; bhd[r] = 0;
      of_s[r] = 0; uf_s[r] = 0; or_rdy[r] = 0;
    end
    drive(-1, 1'b0);
    mac_A_ready = 0; mac_B_ready = 0; mac_out_valid = 0; mac_out_data = '0;
    mac_overflow = 0; mac_underflow = 0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_sat", {mac_OF_saturation, mac_UF_saturation}, 0);
    chk("rst_ready", {req_A_ready, req_B_ready, mac_out_ready}, 0);
    reset = 1'b1;

    // Contention right after reset: expected order 0,1,0,1.
    push_job(0, 6, 4, A_W'($urandom), B_W'($urandom));
    push_job(1, 5, 5, A_W'($urandom), B_W'($urandom));
    run_job(0, 0, 1'b1, 1'b0);
    push_job(0, 4, 6, A_W'($urandom), B_W'($urandom));
    run_job(0, 0, 1'b1, 1'b0);
    push_job(1, 3, 3, A_W'($urandom), B_W'($urandom));
    run_job(0, 0, 1'b0, 1'b0);
    run_job(0, 0, 1'b0, 1'b0);
    idle_check();

    // Single long job from requester 0.
    push_job(0, 30, 30, 16'h1234, 12'h234);
    run_job(0, 0, 1'b0, 1'b0);
    idle_check();

    // Unequal lasts: A closes at beat 7, B at beat 9.
    push_job(0, 7, 9, A_W'($urandom), B_W'($urandom));
    run_job(0, 0, 1'b0, 1'b0);
    idle_check();

    // Result backpressure while the other requester waits.
    push_job(1, 4, 4, A_W'($urandom), B_W'($urandom));
    push_job(0, 3, 3, A_W'($urandom), B_W'($urandom));
    run_job(0, 10, 1'b1, 1'b0);
    run_job(0, 2, 1'b0, 1'b0);
    idle_check();

    // Saturation latched at grant survives the requester dropping it mid-job.
    of_s[1] = 1; uf_s[1] = 1;
    push_job(1, 8, 8, A_W'($urandom), B_W'($urandom));
    run_job(0, 0, 1'b0, 1'b1);
    push_job(0, 3, 2, A_W'($urandom), B_W'($urandom));
    run_job(0, 0, 1'b0, 1'b0);
    idle_check();

    // Mid-job reset abandons requester 1's job.
    push_job(0, 2, 2, A_W'($urandom), B_W'($urandom));
    run_job(0, 0, 1'b0, 1'b0);
    push_job(1, 20, 20, A_W'($urandom), B_W'($urandom));
    run_job(5, 0, 1'b0, 1'b0);
    reset = 1'b0;
    mac_out_valid = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_grant", 32'(grant_id), 0);
    chk("mrst_ready", {req_A_ready, req_B_ready, mac_out_ready}, 0);
    chk("mrst_valid", {mac_A_valid, mac_B_valid, req_out_valid}, 0);
    for (int r = 0; r < int'(NREQ); r++) begin
      alen[r] = 0; ahd[r] = 0; blen[r] = 0; bhd[r] = 0;
    end
    ptr_m = 0;
    drive(-1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("post_rst_idle", busy, 0);
    push_job(1, 3, 3, A_W'($urandom), B_W'($urandom));
    push_job(0, 3, 3, A_W'($urandom), B_W'($urandom));
    run_job(0, 0, 1'b0, 1'b0);
    run_job(0, 0, 1'b0, 1'b0);
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fixed_mac_rr_scheduler.md
Name: fixed_mac_rr_scheduler

Overview:
Round-robin scheduler that shares one fixed_mac instance between NREQ requesters. Each requester presents an A/B valid-ready-last stream pair and gets back its accumulated result on a private out channel. A grant covers one full job: both operand streams through their last beats, then the single result beat. The block sits directly in front of fixed_mac and muxes its A, B and out channels plus its saturation controls.

Parameters:
NREQ, 2, number of requesters (2..4)
WI1, 6, A operand integer bits
WF1, 10, A operand fractional bits
WI2, 4, B operand integer bits
WF2, 8, B operand fractional bits
WIO, 7, result integer bits
WFO, 13, result fractional bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_A_data  in  NREQ*(WI1+WF1)  packed A data, slice i = requester i
req_A_valid/req_A_last  in  NREQ  per-requester A valid / last
req_A_ready  out  NREQ  per-requester A ready
req_B_data  in  NREQ*(WI2+WF2)  packed B data
req_B_valid/req_B_last  in  NREQ  per-requester B valid / last
req_B_ready  out  NREQ  per-requester B ready
req_of_sat/req_uf_sat  in  NREQ  per-requester saturation enables
req_out_data  out  WIO+WFO  result, shared bus
req_out_valid  out  NREQ  result valid, owner bit only
req_out_ready  in  NREQ  per-requester result ready
req_overflow/req_underflow  out  1  flags accompanying result beat
mac_A_data/valid/last, mac_A_ready  out/out/out, in  WI1+WF1/1/1, 1  to fixed_mac A channel
mac_B_data/valid/last, mac_B_ready  out/out/out, in  WI2+WF2/1/1, 1  to fixed_mac B channel
mac_out_data/valid, mac_out_ready  in/in, out  WIO+WFO/1, 1  from fixed_mac out channel
mac_overflow/mac_underflow  in  1  fixed_mac flags
mac_OF_saturation/mac_UF_saturation  out  1  to fixed_mac
busy  out  1  job in progress
grant_id  out  clog2(NREQ) (min 1)  current owner

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy=0; grant_id=0; rr pointer=0; a_done=b_done=0; latched sat bits=0. All readies and valids (req_*_ready, req_out_valid, mac_*_valid, mac_out_ready) are 0 combinationally in IDLE. A reset mid-job abandons the job with no result return, and the bench re-resets fixed_mac with it.
- Request: requester i is requesting when req_A_valid[i] | req_B_valid[i].
- IDLE: if any requester is requesting, pick the first one at or after the pointer in index order. Register grant_id, latch req_of_sat/req_uf_sat, then go to STREAM. Arbitration latency is 1 cycle, and no beat is accepted in the arbitration cycle.
- STREAM: owner's A/B channels pass combinationally to mac_A/mac_B (data, valid, last). Ready returns to the owner only; non-owner readies stay 0.
  - An A beat is accepted on mac_A_valid & mac_A_ready. If its last=1, set a_done; B is symmetric with b_done.
  - Once a_done is set, mac_A_valid=0 and the owner's A ready=0. Same for B.
  - When both are done (including last beats on both in the same cycle), go to RESULT.
- RESULT: mac_out_data, mac_overflow and mac_underflow drive req_out_data and the flags. req_out_valid[grant_id]=mac_out_valid. mac_out_ready=req_out_ready[grant_id].
  - On the out handshake: pointer = grant_id+1 (mod NREQ), clear a_done/b_done, go to IDLE.
  - Result bus is don't-care when req_out_valid is all zero.
- mac_OF_saturation/mac_UF_saturation hold the latched bits from grant until the next grant. Requester changes mid-job are ignored.
- busy=1 in STREAM and RESULT.
- No timeout: a stalled owner holds the grant indefinitely.
- Back-to-back jobs: IDLE occupies at least 1 cycle between jobs.
- Single requester: re-granted every job, no starvation check needed.
- Latency: 0 cycles added on data paths; 1 cycle added for arbitration; 1 cycle added for the return to IDLE.

Decomposition:
- Package fixed_mac_pkg: state enum {IDLE, STREAM, RESULT}; width localparams (A_W=WI1+WF1, B_W=WI2+WF2, O_W=WIO+WFO); requester-id width function.
- Sub-module rr_arbiter: NREQ request vector plus pointer in, one-hot grant and encoded id out; combinational.
- The scheduler holds the FSM, done flags, sat latches and muxes.

Test Plan:
- Single job: requester 0 streams 30 A beats (16'h1234 then random) and 30 B beats (12'h234…), both lasts on the final beat -> grant_id=0, one result to req_out_valid[0], busy deasserts 1 cycle after out handshake.
- Contention: both requesters assert valid in the same cycle after reset -> req 0 served first, then req 1. With req 0 re-requesting, the order is 0,1,0,1.
- Unequal last: A last at beat 7, B last at beat 9 -> req_A_ready[owner]=0 from cycle after A last; RESULT entered only after B last accepted.
- Backpressure: req_out_ready held 0 for 10 cycles in RESULT -> mac_out_ready=0, req_out_valid stays 1, no new grant.
- Saturation latch: req 1 grants with of_sat=1, then drops it mid-job -> mac_OF_saturation stays 1 until next grant.
- Mid-job reset: reset=0 during STREAM beat 5 -> all readies/valids 0 immediately, grant_id=0, IDLE after release.
